// File: rtl/spram_read_arbiter.sv
// spram_read_arbiter: round-robin share of one pipelined SPRAM read port among N_PORTS LED channels.
// Latency: mem_rd_en 1 clk after a request is seen, strobe READ_LATENCY+1 clks after mem_rd_en.
// Backpressure: one read outstanding per port; optional ARB_PORT0_PRIORITY_EN gives port 0 strict priority.
module spram_read_arbiter #(
    parameter int N_PORTS           = 4,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int READ_LATENCY      = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_PORTS*ADDRESS_BUS_WIDTH-1:0]   read_address,
    input  logic [N_PORTS-1:0]                     read_request,
    output logic [15:0]                            read_data,
    output logic [N_PORTS-1:0]                     read_finished_strobe,
    output logic [ADDRESS_BUS_WIDTH-1:0]           mem_addr,
    output logic                                   mem_rd_en,
    input  logic [15:0]                            mem_rd_data
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);
    localparam logic [PW-1:0] ONE       = PW'(1);

    // Arbitration state
    logic [PW-1:0]      r_ptr;
    logic [N_PORTS-1:0] r_busy;

    // Issue stage
    logic [AW-1:0]      r_mem_addr;
    logic               r_mem_rd_en;
    logic [PW-1:0]      r_issue_idx;

    // Tag chain running alongside the SPRAM read pipeline
    logic               r_pipe_vld [READ_LATENCY];
    logic [PW-1:0]      r_pipe_idx [READ_LATENCY];

    // Return stage
    logic [15:0]        r_read_data;
    logic [N_PORTS-1:0] r_strobe;

    logic [N_PORTS-1:0] w_elig;
    logic [N_PORTS-1:0] w_rr_elig;
    logic [PW-1:0]      w_cand;
    logic               w_gnt_vld;
    logic [PW-1:0]      w_gnt_idx;
    logic               w_ptr_upd;
    logic [AW-1:0]      w_gnt_addr;
    logic [N_PORTS-1:0] w_gnt_onehot;
    logic [N_PORTS-1:0] w_ret_onehot;
    logic               w_ret_vld;
    logic [PW-1:0]      w_ret_idx;

    assign w_elig = read_request & ~r_busy;

`ifdef ARB_PORT0_PRIORITY_EN
    // Port 0 is handled outside the rotation, so it never takes part in the search.
    assign w_rr_elig = {w_elig[N_PORTS-1:1], 1'b0};
`else
    assign w_rr_elig = w_elig;
`endif

    // Round-robin search from pointer+1; explicit wrap keeps non-power-of-two N_PORTS in range.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = r_ptr;
        for (int j = 0; j < N_PORTS; j++) begin
            w_cand = (w_cand == LAST_PORT) ? '0 : (w_cand + ONE);
            if (!w_gnt_vld && w_rr_elig[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        w_ptr_upd = w_gnt_vld;
`ifdef ARB_PORT0_PRIORITY_EN
        if (w_elig[0]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = '0;
            w_ptr_upd = 1'b0;
        end
`endif
    end

    always_comb begin
        w_gnt_addr   = '0;
        w_gnt_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_gnt_addr = read_address[i*AW +: AW];
            end
            w_gnt_onehot[i] = w_gnt_vld && (w_gnt_idx == PW'(i));
        end
    end

    assign w_ret_vld = r_pipe_vld[READ_LATENCY-1];
    assign w_ret_idx = r_pipe_idx[READ_LATENCY-1];

    always_comb begin
        w_ret_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_ret_onehot[i] = w_ret_vld && (w_ret_idx == PW'(i));
        end
    end

    // Issue: address is captured only here, so later requester changes cannot disturb the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= LAST_PORT;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_issue_idx <= '0;
        end else begin
            r_mem_rd_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_mem_addr  <= w_gnt_addr;
                r_issue_idx <= w_gnt_idx;
            end
            if (w_ptr_upd) begin
                r_ptr <= w_gnt_idx;
            end
        end
    end

    // A port stays busy until the clk after its strobe, which lets its FIFO full flag settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~r_strobe) | w_gnt_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= r_mem_rd_en;
            r_pipe_idx[0] <= r_issue_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    // Return: data holds between strobes; strobe lasts exactly one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data <= '0;
            r_strobe    <= '0;
        end else begin
            r_strobe <= w_ret_onehot;
            if (w_ret_vld) begin
                r_read_data <= mem_rd_data;
            end
        end
    end

    assign read_data            = r_read_data;
    assign read_finished_strobe = r_strobe;
    assign mem_addr             = r_mem_addr;
    assign mem_rd_en            = r_mem_rd_en;

endmodule
